// File: rtl/fm_pkg.sv
// Shared definitions for the freqmeters scan sequencer.
package fm_pkg;

  // Width of a channel index (up to 32 channels)
  localparam int unsigned FM_CH_W = 5;

  // Default freqmeters register map (byte addresses)
  localparam logic [8:0] FM_STATUS_ADR  = 9'h000;
  localparam logic [8:0] FM_START_BASE  = 9'h020;
  localparam logic [8:0] FM_RESULT_BASE = 9'h100;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_START,
    ST_WAIT,
    ST_RD_STAT,
    ST_SCAN,
    ST_RD_RES,
    ST_PUSH,
    ST_RESTART
  } fm_state_e;

endpackage

// File: rtl/fm_rr_pick.sv
// Round-robin first-set finder: first set bit of pend at or after ptr, wrapping over N.
module fm_rr_pick
  import fm_pkg::*;
#(
  parameter int unsigned N = 24
) (
  input  logic [N-1:0]       pend,
  input  logic [FM_CH_W-1:0] ptr,
  output logic [FM_CH_W-1:0] ch,
  output logic               found
);

  logic [31:0] pend_x;

  assign pend_x = 32'(pend);

  // Walk N positions starting at ptr and keep the first hit
  always_comb begin
    int unsigned j;
    ch    = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!found && pend_x[j[4:0]]) begin
        found = 1'b1;
        ch    = j[FM_CH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fm_scan_sequencer.sv
// Autonomous Wishbone master that starts freqmeter channels, collects results
// on interrupt in round-robin order, streams them out and restarts channels.
module fm_scan_sequencer
  import fm_pkg::*;
#(
  parameter int unsigned      INPUTS_COUNT = 24,
  parameter int unsigned      ADR_W        = 9,
  parameter logic [ADR_W-1:0] STATUS_ADR   = ADR_W'(FM_STATUS_ADR),
  parameter logic [ADR_W-1:0] START_BASE   = ADR_W'(FM_START_BASE),
  parameter logic [ADR_W-1:0] RESULT_BASE  = ADR_W'(FM_RESULT_BASE),
  parameter int unsigned      ACK_TIMEOUT  = 15
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [INPUTS_COUNT-1:0] mask_i,
  input  logic                    cfg_we_i,
  input  logic [FM_CH_W-1:0]      cfg_ch_i,
  input  logic [31:0]             cfg_dat_i,
  input  logic                    inta_i,
  output logic                    m_cyc_o,
  output logic                    m_stb_o,
  output logic                    m_we_o,
  output logic [ADR_W-1:0]        m_adr_o,
  output logic [31:0]             m_dat_o,
  input  logic [31:0]             m_dat_i,
  input  logic                    m_ack_i,
  output logic                    res_valid_o,
  output logic [FM_CH_W-1:0]      res_ch_o,
  output logic [31:0]             res_dat_o,
  input  logic                    res_ready_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned          TMO_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [FM_CH_W-1:0]   LAST_CH = FM_CH_W'(INPUTS_COUNT - 1);

  fm_state_e                 state_q, state_d;
  logic                      cyc_q, cyc_d, we_q, we_d;
  logic [ADR_W-1:0]          adr_q, adr_d;
  logic [31:0]               dat_q, dat_d;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic [FM_CH_W-1:0]        idx_q, idx_d, cur_q, cur_d, rr_q, rr_d, res_ch_q, res_ch_d;
  logic [INPUTS_COUNT-1:0]   mask_q, mask_d, pend_q, pend_d;
  logic                      res_valid_q, res_valid_d, err_q, err_d;
  logic [31:0]               res_dat_q, res_dat_d;
  logic [31:0]               tab [INPUTS_COUNT];
  logic [FM_CH_W-1:0]        pick_ch;
  logic                      pick_found;
  logic                      issue, issue_we, acked, adv, fin;
  logic [ADR_W-1:0]          issue_adr;
  logic [31:0]               issue_dat;

  fm_rr_pick #(.N(INPUTS_COUNT)) u_pick (
    .pend  (pend_q),
    .ptr   (rr_q),
    .ch    (pick_ch),
    .found (pick_found)
  );

  assign m_cyc_o     = cyc_q;
  assign m_stb_o     = cyc_q;
  assign m_we_o      = we_q;
  assign m_adr_o     = adr_q;
  assign m_dat_o     = dat_q;
  assign res_valid_o = res_valid_q;
  assign res_ch_o    = res_ch_q;
  assign res_dat_o   = res_dat_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != ST_IDLE);

  // Reload table: one write port from the CPU side, read asynchronously by the FSM
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < INPUTS_COUNT; i++) tab[i] <= '0;
    end else if (cfg_we_i && (32'(cfg_ch_i) < INPUTS_COUNT)) begin
      tab[cfg_ch_i] <= cfg_dat_i;
    end
  end

  // State and registered bus/stream outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      tmo_q       <= '0;
      idx_q       <= '0;
      cur_q       <= '0;
      rr_q        <= '0;
      mask_q      <= '0;
      pend_q      <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_dat_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      tmo_q       <= tmo_d;
      idx_q       <= idx_d;
      cur_q       <= cur_d;
      rr_q        <= rr_d;
      mask_q      <= mask_d;
      pend_q      <= pend_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_dat_q   <= res_dat_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic; bus states issue when idle, advance on ack, stop on !enable_i
  // before a new access. Bus outputs are computed here and registered above.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    tmo_d       = tmo_q;
    idx_d       = idx_q;
    cur_d       = cur_q;
    rr_d        = rr_q;
    mask_d      = mask_q;
    pend_d      = pend_q;
    res_valid_d = res_valid_q;
    res_ch_d    = res_ch_q;
    res_dat_d   = res_dat_q;
    err_d       = 1'b0;
    issue       = 1'b0;
    issue_we    = 1'b0;
    issue_adr   = '0;
    issue_dat   = '0;
    adv         = 1'b0;
    fin         = 1'b0;
    acked       = cyc_q && m_ack_i;

    if (acked) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
    end else if (cyc_q) begin
      if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          mask_d  = mask_i;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        if (acked) begin
          idx_d   = '0;
          state_d = ST_START;
        end else if (!cyc_q) begin
          if (!enable_i) state_d = ST_IDLE;
          else begin
            issue     = 1'b1;
            issue_we  = 1'b1;
            issue_adr = STATUS_ADR;
            issue_dat = 32'(mask_q);
          end
        end
      end
      ST_START: begin
        if (cyc_q) begin
          adv = acked;
        end else if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (mask_q[idx_q] && (tab[idx_q] != '0)) begin
          issue     = 1'b1;
          issue_we  = 1'b1;
          issue_adr = START_BASE + ADR_W'({idx_q, 2'b00});
          issue_dat = tab[idx_q];
        end else begin
          adv = 1'b1;
        end
        if (adv) begin
          if (idx_q == LAST_CH) state_d = ST_WAIT;
          else                  idx_d   = idx_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (!enable_i)   state_d = ST_IDLE;
        else if (inta_i) state_d = ST_RD_STAT;
      end
      ST_RD_STAT: begin
        if (acked) begin
          pend_d  = m_dat_i[INPUTS_COUNT-1:0] & mask_q;
          state_d = (pend_d != '0) ? ST_SCAN : ST_WAIT;
        end else if (!cyc_q) begin
          if (!enable_i) state_d = ST_IDLE;
          else begin
            issue     = 1'b1;
            issue_adr = STATUS_ADR;
          end
        end
      end
      ST_SCAN: begin
        if (!enable_i) state_d = ST_IDLE;
        else if (pick_found) begin
          cur_d   = pick_ch;
          state_d = ST_RD_RES;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RD_RES: begin
        if (acked) begin
          res_valid_d = 1'b1;
          res_ch_d    = cur_q;
          res_dat_d   = m_dat_i;
          state_d     = ST_PUSH;
        end else if (!cyc_q) begin
          if (!enable_i) state_d = ST_IDLE;
          else begin
            issue     = 1'b1;
            issue_adr = RESULT_BASE + ADR_W'({cur_q, 2'b00});
          end
        end
      end
      ST_PUSH: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = ST_RESTART;
        end
      end
      ST_RESTART: begin
        if (cyc_q) begin
          fin = acked;
        end else if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (tab[cur_q] == '0) begin
          fin = 1'b1;
        end else begin
          issue     = 1'b1;
          issue_we  = 1'b1;
          issue_adr = START_BASE + ADR_W'({cur_q, 2'b00});
          issue_dat = tab[cur_q];
        end
        if (fin) begin
          pend_d  = pend_q & ~(INPUTS_COUNT'(1) << cur_q);
          rr_d    = (cur_q == LAST_CH) ? '0 : cur_q + 1'b1;
          state_d = (pend_d != '0) ? ST_SCAN : ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      cyc_d = 1'b1;
      we_d  = issue_we;
      adr_d = issue_adr;
      dat_d = issue_dat;
      tmo_d = '0;
    end
  end

endmodule
